// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: word type, core count, arbiter states.
package cpu_types_pkg;

  localparam int NUM_CORES = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // A lone requester wins outright; on contention the core that was not served last wins.
  function automatic logic pick_core(input logic [NUM_CORES-1:0] req, input logic last);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    return ~last;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of per-core request/response signals and the shared RAM port of the arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic [NUM_CORES-1:0] dREN;
  logic [NUM_CORES-1:0] dWEN;
  word_t                daddr  [NUM_CORES];
  word_t                dstore [NUM_CORES];
  logic [NUM_CORES-1:0] dhit;
  word_t                dload  [NUM_CORES];

  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_ready;

  logic grant;
  logic busy;

  modport slave (
    input  dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output dhit, dload, ramREN, ramWEN, ramaddr, ramstore, grant, busy
  );

  modport master (
    output dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  dhit, dload, ramREN, ramWEN, ramaddr, ramstore, grant, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-core round-robin arbiter in front of a single-ported RAM.
//   state  | meaning
//   IDLE   | no access in flight, choose a requester
//   ACCESS | RAM driven from the granted core until ram_ready
//   RESP   | one-cycle dhit to the granted core, no new grant
module mem_arbiter
  import cpu_types_pkg::*;
(
  input logic       CLK,
  input logic       nRST,
  mem_arbiter_if.slave bus
);

  arb_state_t           state, state_n;
  logic                 grant, grant_n;
  logic                 last, last_n;
  logic                 load_en;
  logic [NUM_CORES-1:0] req;
  word_t                dload_q [NUM_CORES];

  logic                 ram_ren, ram_wen;
  word_t                ram_addr, ram_store;
  logic [NUM_CORES-1:0] hit;

  assign req = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b0;
      for (int c = 0; c < NUM_CORES; c++) dload_q[c] <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      if (load_en) dload_q[grant] <= bus.ramload;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    load_en = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          grant_n = pick_core(req, last);
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        // A core that withdraws its request abandons the access without affecting fairness.
        if (!req[grant]) begin
          state_n = IDLE;
        end else if (bus.ram_ready) begin
          load_en = 1'b1;
          last_n  = grant;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    hit       = '0;
    if (state == ACCESS) begin
      ram_wen   = bus.dWEN[grant];
      ram_ren   = bus.dREN[grant] & ~bus.dWEN[grant];
      ram_addr  = bus.daddr[grant];
      ram_store = bus.dstore[grant];
    end
    if (state == RESP) hit[grant] = 1'b1;
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.dhit     = hit;
  assign bus.dload    = dload_q;
  assign bus.grant    = grant;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences, random vs. model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  typedef struct {
    logic [1:0] ren;
    logic [1:0] wen;
    word_t      addr;
    word_t      data;
    logic       exp_grant;
    logic       exp_ren;
    logic       exp_wen;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dREN      = '0;
    bus.dWEN      = '0;
    bus.ram_ready = 1'b0;
    bus.ramload   = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      bus.daddr[c]  = '0;
      bus.dstore[c] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // Reference model: transaction-level bookkeeping with plain integers.
  int    m_owner;
  bit    m_resp;
  bit    m_last;
  word_t m_dload [2];

  task automatic model_clear();
    m_owner = -1;
    m_resp  = 1'b0;
    m_last  = 1'b0;
    m_dload[0] = '0;
    m_dload[1] = '0;
  endtask

  task automatic model_check();
    bit o_req_w, o_req_r;
    chk("rnd_busy", bus.busy, (m_owner >= 0) ? 1 : 0);
    chk("rnd_dload0", bus.dload[0], m_dload[0]);
    chk("rnd_dload1", bus.dload[1], m_dload[1]);
    if (m_resp) begin
      chk("rnd_dhit", bus.dhit, (m_owner == 1) ? 2 : 1);
      chk("rnd_resp_strobes", {bus.ramREN, bus.ramWEN}, 0);
    end else begin
      chk("rnd_dhit_quiet", bus.dhit, 0);
      if (m_owner >= 0) begin
        o_req_w = bus.dWEN[m_owner];
        o_req_r = bus.dREN[m_owner] && !o_req_w;
        chk("rnd_ramWEN", bus.ramWEN, o_req_w);
        chk("rnd_ramREN", bus.ramREN, o_req_r);
        chk("rnd_ramaddr", bus.ramaddr, bus.daddr[m_owner]);
        chk("rnd_ramstore", bus.ramstore, bus.dstore[m_owner]);
      end else begin
        chk("rnd_idle_strobes", {bus.ramREN, bus.ramWEN}, 0);
      end
    end
    if (m_owner >= 0) chk("rnd_grant", bus.grant, m_owner);
  endtask

  task automatic model_edge();
    bit r0, r1;
    r0 = bus.dREN[0] | bus.dWEN[0];
    r1 = bus.dREN[1] | bus.dWEN[1];
    if (!nRST) begin
      model_clear();
    end else if (m_resp) begin
      m_resp  = 1'b0;
      m_owner = -1;
    end else if (m_owner >= 0) begin
      if (!(bus.dREN[m_owner] | bus.dWEN[m_owner])) begin
        m_owner = -1;
      end else if (bus.ram_ready) begin
        m_dload[m_owner] = bus.ramload;
        m_last = (m_owner == 1);
        m_resp = 1'b1;
      end
    end else if (r0 && r1) begin
      m_owner = m_last ? 0 : 1;
    end else if (r0) begin
      m_owner = 0;
    end else if (r1) begin
      m_owner = 1;
    end
  endtask

  initial begin
    int hits;
    int expg;
    clear_inputs();

    // Reset state
    do_reset();
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_dhit", bus.dhit, 0);
    chk("rst_strobes", {bus.ramREN, bus.ramWEN}, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_dload0", bus.dload[0], 0);
    chk("rst_dload1", bus.dload[1], 0);

    // Vector table: each applied right after reset, so last=0.
    vecs[0] = '{ren:2'b01, wen:2'b00, addr:32'h0000_0100, data:32'hA5A5_0001, exp_grant:1'b0, exp_ren:1'b1, exp_wen:1'b0};
    vecs[1] = '{ren:2'b00, wen:2'b10, addr:32'h0000_0200, data:32'h5A5A_0002, exp_grant:1'b1, exp_ren:1'b0, exp_wen:1'b1};
    vecs[2] = '{ren:2'b11, wen:2'b00, addr:32'h0000_0300, data:32'h1111_0003, exp_grant:1'b1, exp_ren:1'b1, exp_wen:1'b0};
    vecs[3] = '{ren:2'b10, wen:2'b10, addr:32'h0000_0040, data:32'h0000_1234, exp_grant:1'b1, exp_ren:1'b0, exp_wen:1'b1};
    vecs[4] = '{ren:2'b10, wen:2'b01, addr:32'h0000_0500, data:32'h2222_0005, exp_grant:1'b1, exp_ren:1'b1, exp_wen:1'b0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.dREN = vecs[i].ren;
      bus.dWEN = vecs[i].wen;
      for (int c = 0; c < NUM_CORES; c++) begin
        bus.daddr[c]  = vecs[i].addr + 32'(c * 4);
        bus.dstore[c] = vecs[i].data ^ 32'(c);
      end
      tick();
      chk("vec_grant", bus.grant, vecs[i].exp_grant);
      chk("vec_busy", bus.busy, 1);
      chk("vec_ramREN", bus.ramREN, vecs[i].exp_ren);
      chk("vec_ramWEN", bus.ramWEN, vecs[i].exp_wen);
      chk("vec_ramaddr", bus.ramaddr, vecs[i].addr + 32'(vecs[i].exp_grant) * 4);
      chk("vec_ramstore", bus.ramstore, vecs[i].data ^ 32'(vecs[i].exp_grant));
      bus.ram_ready = 1'b1;
      bus.ramload   = ~vecs[i].data;
      tick();
      chk("vec_dhit", bus.dhit, vecs[i].exp_grant ? 2 : 1);
      chk("vec_dload", bus.dload[vecs[i].exp_grant], ~vecs[i].data);
      clear_inputs();
      tick();
      chk("vec_idle_dhit", bus.dhit, 0);
    end

    // Single read with two wait cycles
    do_reset();
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h100;
    tick();
    chk("rd_ramREN_w1", bus.ramREN, 1);
    chk("rd_ramaddr_w1", bus.ramaddr, 32'h100);
    chk("rd_dhit_w1", bus.dhit, 0);
    tick();
    chk("rd_ramREN_w2", bus.ramREN, 1);
    chk("rd_ramaddr_w2", bus.ramaddr, 32'h100);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'hDEADBEEF;
    tick();
    chk("rd_dhit", bus.dhit, 1);
    chk("rd_dload", bus.dload[0], 32'hDEADBEEF);
    chk("rd_resp_strobes", {bus.ramREN, bus.ramWEN}, 0);
    chk("rd_resp_busy", bus.busy, 1);
    clear_inputs();
    tick();
    chk("rd_dhit_once", bus.dhit, 0);
    chk("rd_dload_hold", bus.dload[0], 32'hDEADBEEF);
    chk("rd_idle", bus.busy, 0);

    // Fairness: both cores request continuously, RAM always ready
    do_reset();
    bus.dREN      = 2'b11;
    bus.ram_ready = 1'b1;
    hits = 0;
    for (int cyc = 0; cyc < 40 && hits < 6; cyc++) begin
      tick();
      if (bus.dhit != 0) begin
        expg = (hits % 2 == 0) ? 1 : 0;
        chk("fair_dhit", bus.dhit, expg ? 2 : 1);
        hits++;
      end
    end
    chk("fair_hit_count", hits, 6);
    clear_inputs();
    tick();

    // Abort: core1 completes (last=1), core0 then withdraws mid-access
    do_reset();
    bus.dWEN[1] = 1'b1;
    bus.ram_ready = 1'b1;
    tick();
    tick();
    chk("ab_pre_hit", bus.dhit, 2);
    clear_inputs();
    tick();
    bus.dREN[0] = 1'b1;
    tick();
    chk("ab_access", bus.busy, 1);
    bus.dREN[0] = 1'b0;
    tick();
    chk("ab_idle", bus.busy, 0);
    chk("ab_no_hit", bus.dhit, 0);
    tick();
    chk("ab_no_hit_late", bus.dhit, 0);
    bus.dREN = 2'b11;
    tick();
    chk("ab_last_kept", bus.grant, 0);
    clear_inputs();
    tick();
    tick();

    // Reset mid-access
    do_reset();
    bus.dWEN[1]   = 1'b1;
    bus.daddr[1]  = 32'h80;
    bus.dstore[1] = 32'h55AA;
    tick();
    chk("rm_access", bus.ramWEN, 1);
    nRST = 1'b0;
    bus.ram_ready = 1'b1;
    tick();
    chk("rm_busy", bus.busy, 0);
    chk("rm_strobes", {bus.ramREN, bus.ramWEN}, 0);
    chk("rm_ramaddr", bus.ramaddr, 0);
    chk("rm_ramstore", bus.ramstore, 0);
    chk("rm_dhit", bus.dhit, 0);
    chk("rm_grant", bus.grant, 0);
    nRST = 1'b1;
    clear_inputs();
    tick();
    chk("rm_dhit_after", bus.dhit, 0);

    // Random traffic against the model
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.dREN[c] = ($urandom_range(0, 1) == 1);
          bus.dWEN[c] = ($urandom_range(0, 2) == 0);
        end
        bus.daddr[c]  = $urandom;
        bus.dstore[c] = $urandom;
      end
      bus.ram_ready = ($urandom_range(0, 2) == 0);
      bus.ramload   = $urandom;
      nRST = ($urandom_range(0, 99) != 0);
      #1;
      model_check();
      @(posedge CLK);
      model_edge();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clock and reset SHALL be: CLK  input  1  system clock; nRST  input  1  synchronous active-low reset, sampled on posedge CLK.
REQ-002 Per core c in {0,1}, inputs SHALL be: dREN[c]  1  read request; dWEN[c]  1  write request; daddr[c]  32 (word_t)  byte address; dstore[c]  32  write data.
REQ-003 Per core c, outputs SHALL be: dhit[c]  1  one-cycle completion pulse; dload[c]  32  read data, valid while dhit[c]=1.
REQ-004 RAM-side outputs SHALL be: ramREN  1; ramWEN  1; ramaddr  32; ramstore  32.
REQ-005 RAM-side inputs SHALL be: ramload  32  read data; ram_ready  1  access complete this cycle.
REQ-006 Debug outputs SHALL be: grant  1  core currently owning RAM; busy  1  FSM not IDLE.

Function
REQ-007 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-008 IDLE: with no request pending (dREN|dWEN)[c]=0 for both cores, the FSM SHALL stay in IDLE and drive ramREN=ramWEN=0.
REQ-009 IDLE: if exactly one core requests, that core SHALL be latched into grant and the FSM SHALL go to ACCESS next cycle.
REQ-010 IDLE: if both cores request, the FSM SHALL grant core (~last); last is a 1-bit round-robin pointer, 0 after reset.
REQ-011 If dREN[c] and dWEN[c] are both 1, the request SHALL be treated as a write.
REQ-012 ACCESS: ramaddr/ramstore SHALL mirror daddr/dstore of the granted core; ramREN/ramWEN SHALL mirror its dREN/dWEN; the other core's signals SHALL be ignored.
REQ-013 ACCESS: when ram_ready=1, dload[grant] SHALL be registered from ramload, last SHALL be set to grant, and the FSM SHALL go to RESP.
REQ-014 ACCESS: the FSM SHALL hold indefinitely while ram_ready=0 (no timeout, no preemption).
REQ-015 ACCESS: if the granted core drops both dREN and dWEN before ram_ready, the FSM SHALL return to IDLE with no dhit and last unchanged.
REQ-016 RESP: dhit[grant]=1 for exactly one cycle, ramREN=ramWEN=0, then the FSM SHALL go to IDLE.
REQ-017 RESP: no new grant SHALL be issued, so a request the requester has not yet cleared is never serviced twice.
REQ-018 Latency SHALL be: request seen in IDLE at cycle n -> RAM driven at n+1 -> dhit at k+1, where k is the ram_ready cycle.
REQ-019 dhit[~grant] SHALL be 0 at all times; dload of a non-hit core SHALL hold its last value.
REQ-020 busy SHALL be 1 in ACCESS and RESP.

Reset
REQ-021 On a posedge CLK with nRST=0, the following SHALL be cleared: state=IDLE, grant=0, last=0, dhit=0, dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-022 Reset asserted mid-ACCESS SHALL abort the access with no dhit; the RAM strobes SHALL be 0 in the cycle following the reset edge.

Structure
REQ-023 The state enum arb_state_t and the constant NUM_CORES=2 SHALL live in cpu_types_pkg; word_t SHALL come from there.
REQ-024 The block SHALL contain a single flat module with no sub-modules; per-core signals SHALL be arrays indexed by core.

Verification
REQ-025 Single read: core0 dREN=1, daddr=0x100; ram_ready asserted 2 cycles later with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for those cycles; dhit[0] one cycle; dload[0]=0xDEADBEEF.
REQ-026 Contention: both cores request in the same cycle after reset -> core1 granted first (last=0), then core0; each receives exactly one dhit.
REQ-027 Fairness: both cores request continuously for 6 transactions -> grants alternate 1,0,1,0,1,0.
REQ-028 Write priority: core1 dREN=dWEN=1, dstore=0x1234, daddr=0x40 -> ramWEN=1, ramREN=0, ramstore=0x1234.
REQ-029 Abort: core0 request drops during ACCESS with ram_ready=0 -> return to IDLE, no dhit, last unchanged.
REQ-030 Reset mid-access: nRST=0 while in ACCESS -> next cycle state IDLE, all outputs 0, no dhit.
